// File: rtl/mem_access_stage.sv
// Memory-access stage: passes ALU results through, or runs one req/ack
// data-memory transaction per LW/SW, and presents one writeback result per op.
module mem_access_stage #(
  parameter int          DW      = 32,
  parameter logic [5:0]  OP_LW   = 6'b001100,
  parameter logic [5:0]  OP_SW   = 6'b001101,
  parameter int          TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    op,
  input  logic [DW-1:0] alu_rd,
  input  logic [DW-1:0] alu_a,
  input  logic [DW-1:0] st_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_wen,
  output logic [1:0]    out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          we_nxt;
  logic [DW-1:0] addr_nxt, wdata_nxt;
  logic          valid_nxt, wen_nxt;
  logic [DW-1:0] data_nxt;
  logic [1:0]    err_nxt;
  logic          accept, is_lw, is_sw, is_mem, aligned;

  // In reset the stage must not advertise readiness, hence the rst_n term.
  assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mem_req  = (state == REQ);

  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_mem  = is_lw || is_sw;
  assign aligned = (alu_a[1:0] == 2'b00);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    valid_nxt = out_valid;
    data_nxt  = out_data;
    wen_nxt   = out_wen;
    err_nxt   = out_err;

    if (out_valid && out_ready) valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mem && aligned) begin
            state_nxt = REQ;
            cnt_nxt   = '0;
            we_nxt    = is_sw;
            addr_nxt  = alu_a;
            wdata_nxt = is_sw ? st_data : '0;
          end else if (is_mem) begin
            valid_nxt = 1'b1;
            data_nxt  = '0;
            wen_nxt   = 1'b0;
            err_nxt   = 2'b01;
          end else begin
            valid_nxt = 1'b1;
            data_nxt  = alu_rd;
            wen_nxt   = 1'b1;
            err_nxt   = 2'b00;
          end
        end
      end
      REQ: begin
        // An ack on the expiry edge still counts as a normal completion.
        if (mem_ack) begin
          state_nxt = IDLE;
          valid_nxt = 1'b1;
          data_nxt  = mem_we ? '0 : mem_rdata;
          wen_nxt   = !mem_we;
          err_nxt   = 2'b00;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          valid_nxt = 1'b1;
          data_nxt  = '0;
          wen_nxt   = 1'b0;
          err_nxt   = 2'b10;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_wen   <= 1'b0;
      out_err   <= 2'b00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_wen   <= wen_nxt;
      out_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage with hand-computed results.
module tb_mem_access_stage;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [5:0]  op;
  logic [31:0] alu_rd, alu_a, st_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        out_valid, out_ready, out_wen;
  logic [31:0] out_data;
  logic [1:0]  out_err;

  int passed = 0;
  int total  = 0;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .alu_rd(alu_rd), .alu_a(alu_a), .st_data(st_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_wen(out_wen), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rd, a, sd;
    int          ack_at;     // REQ cycle (1-based) carrying the ack, 0 = never
    logic [31:0] rdata;
    int          exp_req;    // expected number of mem_req cycles
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_wen;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{6'h00, 32'h0000000F, 32'h0,   32'h0,   0,  32'h0,        0,  1'b0, 32'h0,  32'h0000000F, 1'b1, 2'b00};
    vecs[1] = '{6'h0C, 32'h00000777, 32'h108, 32'h999, 3,  32'hDEADBEEF, 3,  1'b0, 32'h0,  32'hDEADBEEF, 1'b1, 2'b00};
    vecs[2] = '{6'h0D, 32'h00000777, 32'h100, 32'h55,  1,  32'hCAFEF00D, 1,  1'b1, 32'h55, 32'h0,        1'b0, 2'b00};
    vecs[3] = '{6'h0C, 32'h00000777, 32'h102, 32'h0,   0,  32'h0,        0,  1'b0, 32'h0,  32'h0,        1'b0, 2'b01};
    vecs[4] = '{6'h0C, 32'h00000777, 32'h200, 32'h0,   0,  32'h0,        16, 1'b0, 32'h0,  32'h0,        1'b0, 2'b10};
    vecs[5] = '{6'h0C, 32'h00000777, 32'h204, 32'h0,   16, 32'h12345678, 16, 1'b0, 32'h0,  32'h12345678, 1'b1, 2'b00};
    vecs[6] = '{6'h0D, 32'h00000777, 32'h101, 32'h66,  0,  32'h0,        0,  1'b0, 32'h0,  32'h0,        1'b0, 2'b01};
    vecs[7] = '{6'h20, 32'h0000A5A5, 32'h3,   32'h0,   0,  32'h0,        0,  1'b0, 32'h0,  32'h0000A5A5, 1'b1, 2'b00};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; alu_rd = '0; alu_a = '0; st_data = '0;
    mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b1;

    // Reset values
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Table of single transactions
    for (int i = 0; i < 8; i++) begin
      int cycles;
      op = vecs[i].op; alu_rd = vecs[i].rd; alu_a = vecs[i].a; st_data = vecs[i].sd;
      in_valid = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      step();
      in_valid = 1'b0;
      cycles = 0;
      while (mem_req === 1'b1 && cycles < 40) begin
        check($sformatf("v%0d_addr", i), mem_addr, vecs[i].a);
        check($sformatf("v%0d_we", i), mem_we, vecs[i].exp_we);
        check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
        check($sformatf("v%0d_out_valid_in_req", i), out_valid, 0);
        cycles++;
        mem_ack   = (cycles == vecs[i].ack_at);
        mem_rdata = mem_ack ? vecs[i].rdata : 32'hBAD0BAD0;
        step();
        mem_ack = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
      end
      check($sformatf("v%0d_req_cycles", i), cycles, vecs[i].exp_req);
      check($sformatf("v%0d_out_valid", i), out_valid, 1);
      check($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
      check($sformatf("v%0d_out_wen", i), out_wen, vecs[i].exp_wen);
      check($sformatf("v%0d_out_err", i), out_err, vecs[i].exp_err);
      step();
      check($sformatf("v%0d_drained", i), out_valid, 0);
    end

    // Late / spurious ack while idle
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_ack = 1'b0;
    check("spurious_ack_valid", out_valid, 0);
    check("spurious_ack_req", mem_req, 0);

    // Back-to-back pass-through at full rate
    op = 6'h00; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alu_rd = 32'h100 + k;
      #1;
      check($sformatf("b2b%0d_in_ready", k), in_ready, 1);
      step();
      check($sformatf("b2b%0d_valid", k), out_valid, 1);
      check($sformatf("b2b%0d_data", k), out_data, 32'h100 + k);
    end
    in_valid = 1'b0;
    step();
    check("b2b_drained", out_valid, 0);

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0; op = 6'h00; alu_rd = 32'h77; in_valid = 1'b1;
    step();
    alu_rd = 32'h88;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), out_valid, 1);
      check($sformatf("bp%0d_data", k), out_data, 32'h77);
      check($sformatf("bp%0d_in_ready", k), in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_data", out_data, 32'h88);
    step();
    check("bp_drained", out_valid, 0);

    // Reset in the middle of a request, then a stale ack
    op = 6'h0C; alu_a = 32'h300; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("rstreq_req_up", mem_req, 1);
    step(); step();
    rst_n = 1'b0;
    #1;
    check("rstreq_req_drop", mem_req, 0);
    check("rstreq_in_ready", in_ready, 0);
    check("rstreq_valid", out_valid, 0);
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    step();
    mem_ack = 1'b0;
    check("rstreq_stale_ack_valid", out_valid, 0);
    check("rstreq_stale_ack_req", mem_req, 0);
    step();
    check("rstreq_after_valid", out_valid, 0);
    check("rstreq_after_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
